// File: rtl/sec_corrector_pipe_pkg.sv
// rtl/sec_corrector_pipe_pkg.sv - shared constants and position helpers for the SECDED corrector
// Contents: status encodings, is_pow2(), ham_pos() (codeword position of data bit i).
package sec_pkg;

    localparam logic [1:0] ST_CLEAN  = 2'd0;
    localparam logic [1:0] ST_CORR   = 2'd1;
    localparam logic [1:0] ST_UNCORR = 2'd2;

    function automatic logic is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Data bits fill the non-power-of-two positions from 3 upward. Only used
    // to build elaboration-time constants, so the scan loop costs no logic.
    function automatic int ham_pos(input int i);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 3; p < 2 * i + 8; p++) begin
            if (pos == 0 && !is_pow2(p)) begin
                if (n == i) pos = p;
                n++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/sec_corrector_pipe_if.sv
// rtl/sec_corrector_pipe_if.sv - codeword in / result out handshake bundle
// slave: corrector view (consumes in_*, produces out_*); master: source/sink view.
interface sec_corrector_pipe_if #(
    parameter int DATA_W = 32,
    parameter int HAM_W  = 6,
    parameter int KEY_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [HAM_W:0]    in_chk;
    logic              in_corr_en;
    logic [KEY_W-1:0]  key;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [HAM_W-1:0]  out_syndrome;

    modport slave (
        input  in_valid, in_data, in_chk, in_corr_en, key, out_ready,
        output in_ready, out_valid, out_data, out_status, out_syndrome
    );

    modport master (
        output in_valid, in_data, in_chk, in_corr_en, key, out_ready,
        input  in_ready, out_valid, out_data, out_status, out_syndrome
    );
endinterface

// File: rtl/sec_corrector_pipe_syndrome_calc.sv
// rtl/sec_corrector_pipe_syndrome_calc.sv - combinational Hamming syndrome and overall parity
// i_data/i_chk: received word and checks (i_chk[HAM_W] = overall parity);
// o_syn: recomputed checks XOR received checks; o_par: XOR of every received bit.
module sec_syndrome_calc
    import sec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int HAM_W  = 6
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [HAM_W:0]    i_chk,
    output logic [HAM_W-1:0]  o_syn,
    output logic              o_par
);

    logic [HAM_W-1:0] w_pos [DATA_W];
    logic [HAM_W-1:0] w_calc_chk;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
        localparam int POS = ham_pos(gi);
        assign w_pos[gi] = HAM_W'(POS);
    end

    // Each set data bit toggles exactly the check bits named by its position.
    always_comb begin
        w_calc_chk = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i_data[i]) w_calc_chk = w_calc_chk ^ w_pos[i];
        end
    end

    assign o_syn = w_calc_chk ^ i_chk[HAM_W-1:0];
    assign o_par = ^{i_data, i_chk};

endmodule

// File: rtl/sec_corrector_pipe.sv
// rtl/sec_corrector_pipe.sv - two-stage key-locked SECDED checker/corrector with error counters
// clk/rst_n: clock, sync active-low reset; bus: in_* word stream and out_* result stream;
// cnt_clr: clear both counters; cnt_corr/cnt_uncorr: saturating CORRECTED/UNCORRECTABLE counts.
module sec_corrector_pipe
    import sec_pkg::*;
#(
    parameter int               DATA_W      = 32,
    parameter int               HAM_W       = 6,
    parameter int               KEY_W       = 2,
    parameter logic [KEY_W-1:0] CORRECT_KEY = KEY_W'(2'b10),
    parameter int               CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sec_corrector_pipe_if.slave   bus,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt_corr,
    output logic [CNT_W-1:0]      cnt_uncorr
);

    localparam int LAST_POS = ham_pos(DATA_W - 1);

    logic [HAM_W-1:0]  w_syn;
    logic              w_par;
    logic [HAM_W-1:0]  w_syn_used;
    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_out_hs;
    logic [DATA_W-1:0] w_hit;
    logic [DATA_W-1:0] w_dec_data;
    logic [1:0]        w_dec_status;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [HAM_W-1:0]  r_s1_syn;
    logic              r_s1_par;
    logic              r_s1_corr_en;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [1:0]        r_s2_status;
    logic [HAM_W-1:0]  r_s2_syn;

    logic [CNT_W-1:0]  r_cnt_corr;
    logic [CNT_W-1:0]  r_cnt_uncorr;

    sec_syndrome_calc #(
        .DATA_W (DATA_W),
        .HAM_W  (HAM_W)
    ) u_syndrome (
        .i_data (bus.in_data),
        .i_chk  (bus.in_chk),
        .o_syn  (w_syn),
        .o_par  (w_par)
    );

    // A wrong key shifts the syndrome, so the decoder silently mis-corrects.
    assign w_syn_used = w_syn ^ HAM_W'(bus.key ^ CORRECT_KEY);

    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign w_out_hs     = r_s2_valid && bus.out_ready;
    assign bus.in_ready = w_s1_adv;

    // One-hot selector of the data bit whose position equals the syndrome.
    for (genvar gk = 0; gk < DATA_W; gk++) begin : g_hit
        localparam int POS = ham_pos(gk);
        assign w_hit[gk] = (r_s1_syn == HAM_W'(POS));
    end

    always_comb begin
        w_dec_status = ST_CLEAN;
        w_dec_data   = r_s1_data;
        if (!r_s1_par) begin
            if (r_s1_syn != '0) w_dec_status = ST_UNCORR;
        end else if (r_s1_syn == '0 || is_pow2(int'(r_s1_syn))) begin
            // Parity or check-bit error: data is already right.
            w_dec_status = ST_CORR;
        end else if (int'(r_s1_syn) > LAST_POS) begin
            w_dec_status = ST_UNCORR;
        end else begin
            w_dec_status = ST_CORR;
            if (r_s1_corr_en) w_dec_data = r_s1_data ^ w_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_syn     <= '0;
            r_s1_par     <= 1'b0;
            r_s1_corr_en <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_data    <= '0;
            r_s2_status  <= ST_CLEAN;
            r_s2_syn     <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_data    <= bus.in_data;
                    r_s1_syn     <= w_syn_used;
                    r_s1_par     <= w_par;
                    r_s1_corr_en <= bus.in_corr_en;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data   <= w_dec_data;
                    r_s2_status <= w_dec_status;
                    r_s2_syn    <= r_s1_syn;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (w_out_hs) begin
            if (r_s2_status == ST_CORR && r_cnt_corr != '1)
                r_cnt_corr <= r_cnt_corr + 1'b1;
            if (r_s2_status == ST_UNCORR && r_cnt_uncorr != '1)
                r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
        end
    end

    assign bus.out_valid    = r_s2_valid;
    assign bus.out_data     = r_s2_data;
    assign bus.out_status   = r_s2_status;
    assign bus.out_syndrome = r_s2_syn;
    assign cnt_corr         = r_cnt_corr;
    assign cnt_uncorr       = r_cnt_uncorr;

endmodule

// File: tb/tb_sec_corrector_pipe.sv
// tb/tb_sec_corrector_pipe.sv - directed self-checking bench for sec_corrector_pipe
module tb_sec_corrector_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_clr = 1'b0;
    logic        b_clr = 1'b0;
    logic [15:0] a_cnt_corr, a_cnt_uncorr;
    logic [3:0]  b_cnt_corr, b_cnt_uncorr;

    int n_pass  = 0;
    int n_total = 0;
    int exp_corr = 0;
    int exp_uncorr = 0;

    always #5 clk = ~clk;

    sec_corrector_pipe_if #(.DATA_W(32), .HAM_W(6), .KEY_W(2)) a ();
    sec_corrector_pipe_if #(.DATA_W(32), .HAM_W(6), .KEY_W(2)) b ();

    sec_corrector_pipe #(
        .DATA_W(32), .HAM_W(6), .KEY_W(2), .CORRECT_KEY(2'b10), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(a), .cnt_clr(a_clr),
        .cnt_corr(a_cnt_corr), .cnt_uncorr(a_cnt_uncorr)
    );

    sec_corrector_pipe #(
        .DATA_W(32), .HAM_W(6), .KEY_W(2), .CORRECT_KEY(2'b10), .CNT_W(4)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(b), .cnt_clr(b_clr),
        .cnt_corr(b_cnt_corr), .cnt_uncorr(b_cnt_uncorr)
    );

    // Drives one word into the idle main DUT and returns at the negedge where
    // its result is expected on the output (two edges after the handshake).
    task automatic drive_word(input logic [31:0] d, input logic [6:0] c,
                              input logic en, input logic [1:0] k);
        @(negedge clk);
        a.in_valid = 1'b1; a.in_data = d; a.in_chk = c;
        a.in_corr_en = en; a.key = k; a.out_ready = 1'b1;
        @(posedge clk);
        #1 a.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        a.in_valid = 0; a.in_data = 0; a.in_chk = 0; a.in_corr_en = 1; a.key = 2'b10; a.out_ready = 0;
        b.in_valid = 0; b.in_data = 0; b.in_chk = 0; b.in_corr_en = 1; b.key = 2'b10; b.out_ready = 1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (a.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a.out_valid); else n_pass++;
        n_total++; if (a.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", a.in_ready); else n_pass++;
        n_total++; if (a.out_data !== 32'h0 || a.out_status !== 2'd0 || a.out_syndrome !== 6'd0)
            $display("FAIL reset_outputs got %h/%0d/%0d want 0/0/0", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        n_total++; if (a_cnt_corr !== 16'd0 || a_cnt_uncorr !== 16'd0)
            $display("FAIL reset_counters got %0d/%0d want 0/0", a_cnt_corr, a_cnt_uncorr); else n_pass++;
    endtask

    task automatic test_clean;
        @(negedge clk);
        a.in_valid = 1'b1; a.in_data = 32'h0; a.in_chk = 7'h0; a.in_corr_en = 1'b1; a.key = 2'b10; a.out_ready = 1'b1;
        @(posedge clk);
        #1 a.in_valid = 1'b0;
        @(negedge clk);
        n_total++; if (a.out_valid !== 1'b0) $display("FAIL clean_latency1 got out_valid %b want 0", a.out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (a.out_valid !== 1'b1) $display("FAIL clean_latency2 got out_valid %b want 1", a.out_valid); else n_pass++;
        n_total++; if (a.out_data !== 32'h0 || a.out_status !== 2'd0 || a.out_syndrome !== 6'd0)
            $display("FAIL clean_result got %h/%0d/%0d want 0/0/0", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk);
        n_total++; if (a_cnt_corr !== 16'd0 || a_cnt_uncorr !== 16'd0)
            $display("FAIL clean_counters got %0d/%0d want 0/0", a_cnt_corr, a_cnt_uncorr); else n_pass++;
    endtask

    task automatic test_single_error;
        drive_word(32'h0000_0020, 7'h0, 1'b1, 2'b10);
        n_total++; if (a.out_valid !== 1'b1 || a.out_data !== 32'h0 || a.out_status !== 2'd1 || a.out_syndrome !== 6'd10)
            $display("FAIL single_err got v%b %h/%0d/%0d want v1 0/1/10", a.out_valid, a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk); exp_corr++;
        n_total++; if (a_cnt_corr !== 16'(exp_corr)) $display("FAIL single_err_cnt got %0d want %0d", a_cnt_corr, exp_corr); else n_pass++;
        drive_word(32'h8000_0000, 7'h0, 1'b1, 2'b10);
        n_total++; if (a.out_data !== 32'h0 || a.out_status !== 2'd1 || a.out_syndrome !== 6'd38)
            $display("FAIL last_bit got %h/%0d/%0d want 0/1/38", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk); exp_corr++;
    endtask

    task automatic test_detect_only;
        drive_word(32'h0000_0020, 7'h0, 1'b0, 2'b10);
        n_total++; if (a.out_data !== 32'h20 || a.out_status !== 2'd1 || a.out_syndrome !== 6'd10)
            $display("FAIL detect_only got %h/%0d/%0d want 20/1/10", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk); exp_corr++;
    endtask

    task automatic test_double_error;
        drive_word(32'h0000_0003, 7'h0, 1'b1, 2'b10);
        n_total++; if (a.out_data !== 32'h3 || a.out_status !== 2'd2 || a.out_syndrome !== 6'd6)
            $display("FAIL double_err got %h/%0d/%0d want 3/2/6", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk); exp_uncorr++;
        n_total++; if (a_cnt_uncorr !== 16'(exp_uncorr) || a_cnt_corr !== 16'(exp_corr))
            $display("FAIL double_err_cnt got %0d/%0d want %0d/%0d", a_cnt_corr, a_cnt_uncorr, exp_corr, exp_uncorr); else n_pass++;
    endtask

    task automatic test_wrong_key;
        drive_word(32'h0000_0001, 7'h0, 1'b1, 2'b01);
        n_total++; if (a.out_data !== 32'h1 || a.out_status !== 2'd1 || a.out_syndrome !== 6'd0)
            $display("FAIL wrong_key got %h/%0d/%0d want 1/1/0", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk); exp_corr++;
    endtask

    task automatic test_check_bits;
        drive_word(32'h0, 7'b000_0100, 1'b1, 2'b10);
        n_total++; if (a.out_data !== 32'h0 || a.out_status !== 2'd1 || a.out_syndrome !== 6'd4)
            $display("FAIL check_bit_err got %h/%0d/%0d want 0/1/4", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk); exp_corr++;
        drive_word(32'h0, 7'b100_0000, 1'b1, 2'b10);
        n_total++; if (a.out_data !== 32'h0 || a.out_status !== 2'd1 || a.out_syndrome !== 6'd0)
            $display("FAIL parity_bit_err got %h/%0d/%0d want 0/1/0", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk); exp_corr++;
        drive_word(32'h0, 7'b110_1000, 1'b1, 2'b10);
        n_total++; if (a.out_data !== 32'h0 || a.out_status !== 2'd2 || a.out_syndrome !== 6'd40)
            $display("FAIL beyond_last got %h/%0d/%0d want 0/2/40", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        @(negedge clk); exp_uncorr++;
        n_total++; if (a_cnt_corr !== 16'(exp_corr) || a_cnt_uncorr !== 16'(exp_uncorr))
            $display("FAIL counters_mix got %0d/%0d want %0d/%0d", a_cnt_corr, a_cnt_uncorr, exp_corr, exp_uncorr); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [31:0] words [8];
        logic [31:0] prev_data;
        logic [1:0]  prev_status;
        logic [5:0]  prev_syn;
        logic        stalled;
        int tx, rx, bad_order, bad_stable;
        for (int k = 0; k < 8; k++) words[k] = 32'h3 << (3 * k);
        tx = 0; rx = 0; stalled = 1'b0; bad_order = 0; bad_stable = 0;
        prev_data = '0; prev_status = '0; prev_syn = '0;
        for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
            @(negedge clk);
            a.out_ready  = (cyc % 2 == 0);
            a.in_valid   = (tx < 8);
            a.in_data    = (tx < 8) ? words[tx] : 32'h0;
            a.in_chk     = 7'h0;
            a.in_corr_en = 1'b1;
            a.key        = 2'b10;
            #1;
            if (stalled && (a.out_valid !== 1'b1 || a.out_data !== prev_data ||
                            a.out_status !== prev_status || a.out_syndrome !== prev_syn)) begin
                bad_stable++;
                $display("FAIL stall_stable got %h/%0d want %h/%0d", a.out_data, a.out_status, prev_data, prev_status);
            end
            if (a.out_valid && a.out_ready) begin
                if (a.out_data !== words[rx] || a.out_status !== 2'd2) begin
                    bad_order++;
                    $display("FAIL stream_word%0d got %h/%0d want %h/2", rx, a.out_data, a.out_status, words[rx]);
                end
                rx++;
            end
            stalled     = a.out_valid && !a.out_ready;
            prev_data   = a.out_data;
            prev_status = a.out_status;
            prev_syn    = a.out_syndrome;
            if (a.in_valid && a.in_ready) tx++;
        end
        exp_uncorr += 8;
        n_total++; if (rx != 8) $display("FAIL stream_count got %0d want 8", rx); else n_pass++;
        n_total++; if (bad_order != 0) $display("FAIL stream_order got %0d bad want 0", bad_order); else n_pass++;
        n_total++; if (bad_stable != 0) $display("FAIL stream_stall got %0d bad want 0", bad_stable); else n_pass++;
        @(negedge clk);
        a.in_valid = 1'b0; a.out_ready = 1'b1;
        #1;
        n_total++; if (a.out_valid !== 1'b0) $display("FAIL stream_no_dup got out_valid %b want 0", a.out_valid); else n_pass++;
        n_total++; if (a_cnt_uncorr !== 16'(exp_uncorr)) $display("FAIL stream_cnt got %0d want %0d", a_cnt_uncorr, exp_uncorr); else n_pass++;

        // Fill the pipe under stall, then reset with words in flight.
        @(negedge clk);
        a.in_valid = 1'b1; a.in_data = words[1]; a.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; a.in_valid = 1'b0; a.out_ready = 1'b1;
        #1;
        exp_corr = 0; exp_uncorr = 0;
        n_total++; if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1)
            $display("FAIL midreset_hs got v%b r%b want v0 r1", a.out_valid, a.in_ready); else n_pass++;
        n_total++; if (a_cnt_corr !== 16'd0 || a_cnt_uncorr !== 16'd0)
            $display("FAIL midreset_cnt got %0d/%0d want 0/0", a_cnt_corr, a_cnt_uncorr); else n_pass++;
        n_total++; if (a.out_data !== 32'h0 || a.out_status !== 2'd0 || a.out_syndrome !== 6'd0)
            $display("FAIL midreset_out got %h/%0d/%0d want 0/0/0", a.out_data, a.out_status, a.out_syndrome); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (a.out_valid !== 1'b0) $display("FAIL midreset_flush got out_valid %b want 0", a.out_valid); else n_pass++;
    endtask

    task automatic test_saturation;
        int sent, got;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 100 && got < 17; cyc++) begin
            @(negedge clk);
            b.in_valid = (sent < 17); b.in_data = 32'h1; b.in_chk = 7'h0;
            b.in_corr_en = 1'b1; b.key = 2'b10; b.out_ready = 1'b1;
            #1;
            if (b.out_valid && b.out_ready) got++;
            if (b.in_valid && b.in_ready) sent++;
        end
        @(negedge clk);
        b.in_valid = 1'b0;
        #1;
        n_total++; if (got != 17) $display("FAIL sat_words got %0d want 17", got); else n_pass++;
        n_total++; if (b_cnt_corr !== 4'hF) $display("FAIL sat_cnt got %0d want 15", b_cnt_corr); else n_pass++;
        n_total++; if (b_cnt_uncorr !== 4'h0) $display("FAIL sat_uncorr got %0d want 0", b_cnt_uncorr); else n_pass++;
        @(negedge clk);
        b.in_valid = 1'b1; b.in_data = 32'h1;
        @(posedge clk);
        #1 b.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (b.out_valid !== 1'b1 || b.out_status !== 2'd1)
            $display("FAIL clr_word got v%b st%0d want v1 st1", b.out_valid, b.out_status); else n_pass++;
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        #1;
        n_total++; if (b_cnt_corr !== 4'h0) $display("FAIL clr_priority got %0d want 0", b_cnt_corr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_detect_only();
        test_double_error();
        test_wrong_key();
        test_check_bits();
        test_backpressure();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
